// File: rtl/rv32v_types_pkg.sv
// Shared types for the RV32V memory sequencer: FSM states, element widths, LSC access types
// and the width helpers used by the sequencer and its address generator.
package rv32v_types_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StVrun  = 2'd1,
        StVdone = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        Sew8  = 2'd0,
        Sew16 = 2'd1,
        Sew32 = 2'd2
    } sew_t;

    typedef enum logic [2:0] {
        LoadLb  = 3'd0,
        LoadLh  = 3'd1,
        LoadLw  = 3'd2,
        LoadLbu = 3'd3,
        LoadLhu = 3'd4
    } load_t;

    // Vector elements are always fetched zero-extended.
    function automatic load_t sew_to_load_t(sew_t sew);
        case (sew)
            Sew8:    return LoadLbu;
            Sew16:   return LoadLhu;
            default: return LoadLw;
        endcase
    endfunction

    function automatic logic [2:0] sew_bytes(sew_t sew);
        case (sew)
            Sew8:    return 3'd1;
            Sew16:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/rv32v_mem_seq_agu.sv
// Element address generator: holds the running element address and index, applies the
// stride per completed element, and flags the last element and misaligned addresses.
module rv32v_mem_seq_agu
    import rv32v_types_pkg::*;
#(
    parameter int unsigned MAX_VL = 32,
    localparam int unsigned CNT_W = $clog2(MAX_VL + 1),
    localparam int unsigned IDX_W = $clog2(MAX_VL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [31:0]      base,
    input  logic [31:0]      stride,
    input  logic [CNT_W-1:0] vl,
    input  sew_t             sew,
    output logic [31:0]      cur_addr,
    output logic [IDX_W-1:0] idx,
    output sew_t             cur_sew,
    output logic             last,
    output logic             misaligned
);

    logic [31:0]      cur_addr_q;
    logic [31:0]      stride_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] vl_q;
    sew_t             sew_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr_q <= '0;
            stride_q   <= '0;
            idx_q      <= '0;
            vl_q       <= '0;
            sew_q      <= Sew8;
        end else if (load) begin
            cur_addr_q <= base;
            stride_q   <= stride;
            idx_q      <= '0;
            vl_q       <= vl;
            sew_q      <= sew;
        end else if (advance) begin
            // Wraps modulo 2^32 for negative strides and address overflow alike.
            cur_addr_q <= cur_addr_q + stride_q;
            idx_q      <= idx_q + IDX_W'(1);
        end
    end

    assign cur_addr   = cur_addr_q;
    assign idx        = idx_q;
    assign cur_sew    = sew_q;
    assign last       = (CNT_W'(idx_q) == (vl_q - CNT_W'(1)));
    assign misaligned = (cur_addr_q & (32'(sew_bytes(sew_q)) - 32'd1)) != 32'd0;

endmodule

// File: rtl/rv32v_mem_seq.sv
// Vector memory sequencer sharing the scalar LSC port between the scalar pipeline and the
// vector unit. Optional per-element masking is enabled with RV32V_MEM_SEQ_MASK_EN.
module rv32v_mem_seq
    import rv32v_types_pkg::*;
#(
    parameter int unsigned MAX_VL = 32,
    localparam int unsigned CNT_W = $clog2(MAX_VL + 1),
    localparam int unsigned IDX_W = $clog2(MAX_VL)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             s_wen,
    input  logic             s_ren,
    input  logic [31:0]      s_addr,
    input  logic [31:0]      s_store_data,
    input  load_t            s_load_type,
    input  logic             s_ifence,
    output logic [31:0]      s_dload_ext,
    output logic             s_stall,
    input  logic             v_req,
    output logic             v_ready,
    input  logic             v_store,
    input  logic [31:0]      v_base,
    input  logic [31:0]      v_stride,
    input  logic [CNT_W-1:0] v_vl,
    input  sew_t             v_sew,
`ifdef RV32V_MEM_SEQ_MASK_EN
    input  logic [MAX_VL-1:0] v_mask,
`endif
    output logic [IDX_W-1:0] v_elem_idx,
    input  logic [31:0]      v_store_data,
    output logic             v_load_valid,
    output logic [31:0]      v_load_data,
    output logic             v_done,
    output logic             v_fault,
    output logic             lsc_wen,
    output logic             lsc_ren,
    output logic [31:0]      lsc_addr,
    output logic [31:0]      lsc_store_data,
    output load_t            lsc_load_type,
    output logic             lsc_ifence,
    input  logic [31:0]      lsc_dload_ext,
    input  logic             lsc_busy,
    input  logic             lsc_fence_stall
);

    seq_state_t state_q, state_d;
    logic       store_q;
    logic       accept, advance;
    logic       elem_active;
    logic       last, misaligned;
    logic [31:0] cur_addr;
    sew_t        cur_sew;

    rv32v_mem_seq_agu #(
        .MAX_VL(MAX_VL)
    ) u_agu (
        .clk       (CLK),
        .rst       (RST),
        .load      (accept),
        .advance   (advance),
        .base      (v_base),
        .stride    (v_stride),
        .vl        (v_vl),
        .sew       (v_sew),
        .cur_addr  (cur_addr),
        .idx       (v_elem_idx),
        .cur_sew   (cur_sew),
        .last      (last),
        .misaligned(misaligned)
    );

`ifdef RV32V_MEM_SEQ_MASK_EN
    logic [MAX_VL-1:0] mask_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= v_mask;
        end
    end

    assign elem_active = mask_q[v_elem_idx];
`else
    assign elem_active = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                store_q <= v_store;
            end
        end
    end

    assign s_dload_ext = lsc_dload_ext;
    assign v_load_data = lsc_dload_ext;

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        advance        = 1'b0;
        v_ready        = 1'b0;
        v_load_valid   = 1'b0;
        v_done         = 1'b0;
        v_fault        = 1'b0;
        s_stall        = lsc_busy | lsc_fence_stall;
        lsc_wen        = s_wen;
        lsc_ren        = s_ren;
        lsc_ifence     = s_ifence;
        lsc_addr       = s_addr;
        lsc_store_data = s_store_data;
        lsc_load_type  = s_load_type;

        case (state_q)
            StIdle: begin
                // Scalar traffic has priority over a new vector op.
                v_ready = !(s_wen | s_ren | s_ifence);
                if (v_req && v_ready) begin
                    accept  = 1'b1;
                    state_d = (v_vl == '0) ? StVdone : StVrun;
                end
            end
            StVrun: begin
                s_stall        = 1'b1;
                lsc_wen        = 1'b0;
                lsc_ren        = 1'b0;
                lsc_ifence     = 1'b0;
                lsc_addr       = cur_addr;
                lsc_store_data = v_store_data;
                lsc_load_type  = sew_to_load_t(cur_sew);
                if (!elem_active) begin
                    advance = 1'b1;
                    state_d = last ? StVdone : StVrun;
                end else if (misaligned) begin
                    v_fault = 1'b1;
                    state_d = StIdle;
                end else begin
                    lsc_wen = store_q;
                    lsc_ren = !store_q;
                    if (!lsc_busy) begin
                        v_load_valid = !store_q;
                        advance      = 1'b1;
                        state_d      = last ? StVdone : StVrun;
                    end
                end
            end
            StVdone: begin
                s_stall    = 1'b1;
                lsc_wen    = 1'b0;
                lsc_ren    = 1'b0;
                lsc_ifence = 1'b0;
                v_done     = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_rv32v_mem_seq.sv
// Scoreboard bench for rv32v_mem_seq: directed ops push expected LSC requests, element loads
// and completion events; a negedge monitor pops and compares whenever the DUT presents one.
module tb_rv32v_mem_seq;
    import rv32v_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        s_wen = 1'b0, s_ren = 1'b0, s_ifence = 1'b0;
    logic [31:0] s_addr = '0, s_store_data = '0;
    load_t       s_load_type = LoadLb;
    logic [31:0] s_dload_ext;
    logic        s_stall;
    logic        v_req = 1'b0, v_store = 1'b0;
    logic        v_ready;
    logic [31:0] v_base = '0, v_stride = '0;
    logic [5:0]  v_vl = '0;
    sew_t        v_sew = Sew8;
`ifdef RV32V_MEM_SEQ_MASK_EN
    logic [31:0] v_mask = '1;
`endif
    logic [4:0]  v_elem_idx;
    logic [31:0] v_store_data;
    logic        v_load_valid;
    logic [31:0] v_load_data;
    logic        v_done, v_fault;
    logic        lsc_wen, lsc_ren, lsc_ifence;
    logic [31:0] lsc_addr, lsc_store_data, lsc_dload_ext;
    load_t       lsc_load_type;
    logic        lsc_busy = 1'b0;
    logic        lsc_fence_stall = 1'b0;

    rv32v_mem_seq #(
        .MAX_VL(32)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .s_wen          (s_wen),
        .s_ren          (s_ren),
        .s_addr         (s_addr),
        .s_store_data   (s_store_data),
        .s_load_type    (s_load_type),
        .s_ifence       (s_ifence),
        .s_dload_ext    (s_dload_ext),
        .s_stall        (s_stall),
        .v_req          (v_req),
        .v_ready        (v_ready),
        .v_store        (v_store),
        .v_base         (v_base),
        .v_stride       (v_stride),
        .v_vl           (v_vl),
        .v_sew          (v_sew),
`ifdef RV32V_MEM_SEQ_MASK_EN
        .v_mask         (v_mask),
`endif
        .v_elem_idx     (v_elem_idx),
        .v_store_data   (v_store_data),
        .v_load_valid   (v_load_valid),
        .v_load_data    (v_load_data),
        .v_done         (v_done),
        .v_fault        (v_fault),
        .lsc_wen        (lsc_wen),
        .lsc_ren        (lsc_ren),
        .lsc_addr       (lsc_addr),
        .lsc_store_data (lsc_store_data),
        .lsc_load_type  (lsc_load_type),
        .lsc_ifence     (lsc_ifence),
        .lsc_dload_ext  (lsc_dload_ext),
        .lsc_busy       (lsc_busy),
        .lsc_fence_stall(lsc_fence_stall)
    );

    always #5 CLK = ~CLK;

    // VRF read model and LSC read data model.
    assign v_store_data  = {24'h5A5A5A, 3'b000, v_elem_idx};
    assign lsc_dload_ext = lsc_addr ^ 32'hA5A5_0000;

    typedef struct {
        logic        wen;
        logic        ren;
        logic [31:0] addr;
        logic [31:0] data;
        load_t       lt;
    } req_t;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } ld_t;

    typedef struct {
        logic [1:0] kind;  // {fault, done}
        int         cyc;
    } evt_t;

    req_t exp_req_q[$];
    ld_t  exp_ld_q[$];
    evt_t exp_evt_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int busy_cfg = 0;
    int wait_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // LSC model: each transaction is held busy for busy_cfg cycles before completing.
    always @(posedge CLK) begin
        #2;
        if (lsc_wen || lsc_ren) begin
            if (wait_cnt < busy_cfg) begin
                lsc_busy = 1'b1;
                wait_cnt++;
            end else begin
                lsc_busy = 1'b0;
                wait_cnt = 0;
            end
        end else begin
            lsc_busy = 1'b0;
            wait_cnt = 0;
        end
    end

    logic        hold_pending = 1'b0;
    logic [31:0] hold_addr;
    logic [1:0]  hold_strb;

    always @(negedge CLK) begin
        if (RST) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                chk("hold_addr", lsc_addr, hold_addr);
                chk("hold_strb", 32'({lsc_wen, lsc_ren}), 32'(hold_strb));
            end
            hold_pending = 1'b0;
            if (lsc_wen || lsc_ren) begin
                if (lsc_busy) begin
                    hold_pending = 1'b1;
                    hold_addr    = lsc_addr;
                    hold_strb    = {lsc_wen, lsc_ren};
                end else if (exp_req_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_req: got addr 0x%08h, none expected (cycle %0d)",
                             lsc_addr, cyc);
                end else begin
                    req_t r;
                    r = exp_req_q.pop_front();
                    chk("req_strb", 32'({lsc_wen, lsc_ren}), 32'({r.wen, r.ren}));
                    chk("req_addr", lsc_addr, r.addr);
                    chk("req_data", lsc_store_data, r.data);
                    chk("req_type", 32'(lsc_load_type), 32'(r.lt));
                end
            end
            if (v_load_valid) begin
                if (exp_ld_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_load: got idx %0d, none expected (cycle %0d)",
                             v_elem_idx, cyc);
                end else begin
                    ld_t l;
                    l = exp_ld_q.pop_front();
                    chk("load_idx", 32'(v_elem_idx), 32'(l.idx));
                    chk("load_data", v_load_data, l.data);
                end
            end
            if (v_done || v_fault) begin
                if (exp_evt_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_evt: got done=%0b fault=%0b, none expected (cycle %0d)",
                             v_done, v_fault, cyc);
                end else begin
                    evt_t e;
                    e = exp_evt_q.pop_front();
                    chk("evt_kind", 32'({v_fault, v_done}), 32'(e.kind));
                    chk("evt_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic push_req(input logic wen, input logic [31:0] addr, input logic [31:0] data,
                            input load_t lt);
        req_t r;
        r.wen  = wen;
        r.ren  = !wen;
        r.addr = addr;
        r.data = data;
        r.lt   = lt;
        exp_req_q.push_back(r);
    endtask

    task automatic push_ld(input logic [4:0] idx, input logic [31:0] data);
        ld_t l;
        l.idx  = idx;
        l.data = data;
        exp_ld_q.push_back(l);
    endtask

    // Called at #1 after a posedge; returns at #1 after the posedge following acceptance.
    task automatic start_vec(input logic st, input logic [31:0] base, input logic [31:0] stride,
                             input logic [5:0] vl, input sew_t sew, input logic [1:0] kind,
                             input int off, output int waits, output int acc_cyc);
        logic accepted;
        v_store  = st;
        v_base   = base;
        v_stride = stride;
        v_vl     = vl;
        v_sew    = sew;
        v_req    = 1'b1;
        accepted = 1'b0;
        waits    = 0;
        acc_cyc  = 0;
        for (int i = 0; i < 10 && !accepted; i++) begin
            @(negedge CLK);
            if (v_ready) begin
                accepted = 1'b1;
                acc_cyc  = cyc;
                if (kind != 2'b00) begin
                    evt_t e;
                    e.kind = kind;
                    e.cyc  = cyc + off;
                    exp_evt_q.push_back(e);
                end
            end else begin
                waits++;
                @(posedge CLK);
                #1;
            end
        end
        chk("vec_accepted", 32'(accepted), 32'd1);
        @(posedge CLK);
        #1;
        v_req = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (exp_req_q.size() == 0 && exp_ld_q.size() == 0 && exp_evt_q.size() == 0) break;
            @(posedge CLK);
            #1;
        end
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        chk({name, "_pending"},
            32'(exp_req_q.size() + exp_ld_q.size() + exp_evt_q.size()), 32'd0);
    endtask

    int w, a;

    initial begin
        // Reset state.
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("rst_done", 32'(v_done), 32'd0);
        chk("rst_fault", 32'(v_fault), 32'd0);
        chk("rst_lvalid", 32'(v_load_valid), 32'd0);
        chk("rst_idx", 32'(v_elem_idx), 32'd0);
        chk("rst_lsc_strb", 32'({lsc_wen, lsc_ren, lsc_ifence}), 32'd0);
        chk("rst_lsc_addr", lsc_addr, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_ready", 32'(v_ready), 32'd1);
        chk("idle_stall", 32'(s_stall), 32'd0);

        // Scalar passthrough with two busy cycles.
        @(posedge CLK);
        #1;
        busy_cfg    = 2;
        s_ren       = 1'b1;
        s_addr      = 32'h0000_0100;
        s_load_type = LoadLw;
        push_req(1'b0, 32'h0000_0100, 32'h0, LoadLw);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("sc_ren", 32'(lsc_ren), 32'd1);
            chk("sc_stall", 32'(s_stall), (i < 2) ? 32'd1 : 32'd0);
            if (i == 2) chk("sc_dload", s_dload_ext, 32'hA5A5_0100);
            @(posedge CLK);
            #1;
        end
        s_ren = 1'b0;
        drain("scalar");

        // Unit-stride word load, no busy: done at accept + vl + 1.
        busy_cfg = 0;
        for (int i = 0; i < 4; i++) begin
            push_req(1'b0, 32'h1000 + 32'(4 * i), 32'h5A5A_5A00 + 32'(i), LoadLw);
        end
        push_ld(5'd0, 32'hA5A5_1000);
        push_ld(5'd1, 32'hA5A5_1004);
        push_ld(5'd2, 32'hA5A5_1008);
        push_ld(5'd3, 32'hA5A5_100C);
        start_vec(1'b0, 32'h1000, 32'd4, 6'd4, Sew32, 2'b01, 5, w, a);
        drain("unit_load");

        // Negative-stride byte store, one busy cycle per element.
        busy_cfg = 1;
        push_req(1'b1, 32'h2003, 32'h5A5A_5A00, LoadLbu);
        push_req(1'b1, 32'h2002, 32'h5A5A_5A01, LoadLbu);
        push_req(1'b1, 32'h2001, 32'h5A5A_5A02, LoadLbu);
        start_vec(1'b1, 32'h2003, 32'hFFFF_FFFF, 6'd3, Sew8, 2'b01, 7, w, a);
        drain("byte_store");

        // Scalar and vector in the same cycle: scalar first, vector the next cycle.
        busy_cfg    = 0;
        s_ren       = 1'b1;
        s_addr      = 32'h0000_0200;
        v_req       = 1'b1;
        push_req(1'b0, 32'h0000_0200, 32'h0, LoadLw);
        @(negedge CLK);
        chk("conflict_ready", 32'(v_ready), 32'd0);
        @(posedge CLK);
        #1;
        s_ren = 1'b0;
        push_req(1'b0, 32'h4000, 32'h5A5A_5A00, LoadLw);
        push_req(1'b0, 32'h4008, 32'h5A5A_5A01, LoadLw);
        push_ld(5'd0, 32'hA5A5_4000);
        push_ld(5'd1, 32'hA5A5_4008);
        start_vec(1'b0, 32'h4000, 32'd8, 6'd2, Sew32, 2'b01, 3, w, a);
        chk("conflict_waits", 32'(w), 32'd0);
        drain("conflict");

        // vl = 0: done one cycle after accept, no LSC request.
        start_vec(1'b0, 32'h5000, 32'd4, 6'd0, Sew32, 2'b01, 1, w, a);
        drain("vl_zero");

        // Misaligned halfword: fault on first element, no request.
        start_vec(1'b0, 32'h3001, 32'd2, 6'd2, Sew16, 2'b10, 1, w, a);
        drain("fault");

        // Reset during element 2 of an 8-element load.
        push_req(1'b0, 32'h6000, 32'h5A5A_5A00, LoadLw);
        push_req(1'b0, 32'h6004, 32'h5A5A_5A01, LoadLw);
        push_ld(5'd0, 32'hA5A5_6000);
        push_ld(5'd1, 32'hA5A5_6004);
        start_vec(1'b0, 32'h6000, 32'd4, 6'd8, Sew32, 2'b00, 0, w, a);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rstmid_ready", 32'(v_ready), 32'd1);
        chk("rstmid_ren", 32'(lsc_ren), 32'd0);
        chk("rstmid_idx", 32'(v_elem_idx), 32'd0);
        chk("rstmid_stall", 32'(s_stall), 32'd0);
        @(posedge CLK);
        #1;
        drain("reset_mid");

`ifdef RV32V_MEM_SEQ_MASK_EN
        // Masked elements are skipped in one cycle each.
        v_mask = 32'b1010;
        push_req(1'b0, 32'h7004, 32'h5A5A_5A01, LoadLw);
        push_req(1'b0, 32'h700C, 32'h5A5A_5A03, LoadLw);
        push_ld(5'd1, 32'hA5A5_7004);
        push_ld(5'd3, 32'hA5A5_700C);
        start_vec(1'b0, 32'h7000, 32'd4, 6'd4, Sew32, 2'b01, 5, w, a);
        drain("mask");
        v_mask = '1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
